// File: rtl/tipi_link_if.sv
// TIPI 3-wire serial link bundle: the master drives clock, direction, strobe and data;
// the target returns serial data/parity and a reset request.
interface tipi_link_if;
    logic tclk;
    logic rt;
    logic le;
    logic dout;
    logic dc;
    logic din;
    logic treset;

    modport master (output tclk, rt, le, dout, dc, input din, treset);
    modport slave  (input tclk, rt, le, dout, dc, output din, treset);
endinterface

// File: rtl/tipi_link_target.sv
// TIPI link target endpoint: serialises TC/TD bytes to the master and deserialises RC/RD bytes.
// Optional retry statistics are enabled with the TIPI_LINK_STATS_EN macro.
module tipi_link_target #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    tipi_link_if.slave  link,
    input  logic        host_treset,
    input  logic [0:7]  tx_ctrl,
    input  logic [0:7]  tx_data,
    output logic        tx_sent,
    output logic        tx_sent_ctrl,
    output logic        rx_valid,
    output logic        rx_ctrl,
    output logic [0:7]  rx_byte
`ifdef TIPI_LINK_STATS_EN
    ,
    input  logic        stats_clr,
    output logic [0:15] tx_retries,
    output logic [0:15] rx_retries
`endif
);

    localparam int SYNC_DEPTH = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_SEND_DONE = 3'd2,
        ST_RECV      = 3'd3,
        ST_RECV_DONE = 3'd4
    } state_t;

    function automatic logic parity8(input logic [0:7] b);
        return ^b;
    endfunction

    logic [SYNC_DEPTH-1:0][4:0] sync_r;
    logic                       tclk_prev_r;
    logic [4:0]                 link_raw_s;
    logic                       tclk_s, rt_s, le_s, dout_s, dc_s, rise_s;

    state_t      state_r, state_next_s;
    logic [0:7]  txb_r, txb_next_s, tx_sel_s;
    logic [0:7]  shift_r, shift_next_s, rx_word_s;
    logic [3:0]  bit_r, bit_next_s;
    logic        sdc_r, sdc_next_s, rdc_r, rdc_next_s;
    logic        din_r, din_next_s;
    logic        treset_r;
    logic        tx_sent_r, tx_sent_ctrl_r, tx_sent_ctrl_next_s;
    logic        rx_valid_r, rx_ctrl_r, rx_ctrl_next_s;
    logic [0:7]  rx_byte_r, rx_byte_next_s;

    logic fresh_s, load_tx_s, tx_bit_s, tx_par_s, sent_s;
    logic start_rx_s, rx_bit_s, rx_last_s, ack_s;

    assign link_raw_s = {link.tclk, link.rt, link.le, link.dout, link.dc};
    assign tclk_s     = sync_r[SYNC_DEPTH-1][4];
    assign rt_s       = sync_r[SYNC_DEPTH-1][3];
    assign le_s       = sync_r[SYNC_DEPTH-1][2];
    assign dout_s     = sync_r[SYNC_DEPTH-1][1];
    assign dc_s       = sync_r[SYNC_DEPTH-1][0];
    assign rise_s     = tclk_s & ~tclk_prev_r;

    // Input synchroniser chain and tclk edge history.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r      <= '0;
            tclk_prev_r <= 1'b0;
        end else begin
            sync_r      <= {sync_r[SYNC_DEPTH-2:0], link_raw_s};
            tclk_prev_r <= tclk_s;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decision at each synchronised tclk rise.
    always_comb begin
        state_next_s = state_r;
        fresh_s      = 1'b0;
        load_tx_s    = 1'b0;
        tx_bit_s     = 1'b0;
        tx_par_s     = 1'b0;
        sent_s       = 1'b0;
        start_rx_s   = 1'b0;
        rx_bit_s     = 1'b0;
        rx_last_s    = 1'b0;
        ack_s        = 1'b0;
        if (rise_s) begin
            case (state_r)
                ST_IDLE: begin
                    fresh_s = 1'b1;
                end
                ST_SEND: begin
                    if (!rt_s) begin
                        fresh_s = 1'b1;
                    end else if (bit_r == 4'd8) begin
                        tx_par_s     = 1'b1;
                        state_next_s = ST_SEND_DONE;
                    end else begin
                        tx_bit_s = 1'b1;
                    end
                end
                ST_SEND_DONE: begin
                    if (rt_s && le_s && (dc_s == sdc_r)) begin
                        load_tx_s    = 1'b1;
                        state_next_s = ST_SEND;
                    end else if ((dc_s != sdc_r) || !rt_s) begin
                        sent_s  = 1'b1;
                        fresh_s = 1'b1;
                    end else begin
                        state_next_s = ST_SEND_DONE;
                    end
                end
                ST_RECV: begin
                    if (rt_s) begin
                        fresh_s = 1'b1;
                    end else if (bit_r == 4'd7) begin
                        rx_last_s    = 1'b1;
                        state_next_s = ST_RECV_DONE;
                    end else begin
                        rx_bit_s = 1'b1;
                    end
                end
                ST_RECV_DONE: begin
                    if (le_s) begin
                        ack_s        = 1'b1;
                        state_next_s = ST_IDLE;
                    end else if (!rt_s) begin
                        start_rx_s   = 1'b1;
                        state_next_s = ST_RECV;
                    end else begin
                        fresh_s = 1'b1;
                    end
                end
                default: begin
                    fresh_s = 1'b1;
                end
            endcase
            // A fresh evaluation treats this rise as if the target were idle.
            if (!fresh_s) begin
                fresh_s = 1'b0;
            end else if (rt_s && le_s) begin
                load_tx_s    = 1'b1;
                state_next_s = ST_SEND;
            end else if (!rt_s && !le_s) begin
                start_rx_s   = 1'b1;
                state_next_s = ST_RECV;
            end else begin
                state_next_s = ST_IDLE;
            end
        end else begin
            state_next_s = state_r;
        end
    end

    // Datapath and output next values driven by the decoded rise action.
    always_comb begin
        txb_next_s          = txb_r;
        sdc_next_s          = sdc_r;
        bit_next_s          = bit_r;
        shift_next_s        = shift_r;
        rdc_next_s          = rdc_r;
        din_next_s          = din_r;
        rx_byte_next_s      = rx_byte_r;
        rx_ctrl_next_s      = rx_ctrl_r;
        tx_sent_ctrl_next_s = tx_sent_ctrl_r;
        rx_word_s           = {shift_r[1:7], dout_s};
        tx_sel_s            = dc_s ? tx_data : tx_ctrl;
        if (load_tx_s) begin
            txb_next_s = tx_sel_s;
            sdc_next_s = dc_s;
            din_next_s = tx_sel_s[0];
            bit_next_s = 4'd1;
        end else if (tx_bit_s) begin
            din_next_s = txb_r[bit_r[2:0]];
            bit_next_s = bit_r + 4'd1;
        end else if (tx_par_s) begin
            din_next_s = parity8(txb_r);
        end else if (start_rx_s) begin
            shift_next_s = {7'd0, dout_s};
            bit_next_s   = 4'd1;
        end else if (rx_bit_s) begin
            shift_next_s = rx_word_s;
            bit_next_s   = bit_r + 4'd1;
        end else if (rx_last_s) begin
            shift_next_s = rx_word_s;
            din_next_s   = parity8(rx_word_s);
            rdc_next_s   = dc_s;
        end else begin
            din_next_s = din_r;
        end
        if (ack_s) begin
            rx_byte_next_s = shift_r;
            rx_ctrl_next_s = ~rdc_r;
        end else begin
            rx_byte_next_s = rx_byte_r;
            rx_ctrl_next_s = rx_ctrl_r;
        end
        // The sent byte's type comes from the old sdc even if a new byte loads on this rise.
        if (sent_s) begin
            tx_sent_ctrl_next_s = ~sdc_r;
        end else begin
            tx_sent_ctrl_next_s = tx_sent_ctrl_r;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            txb_r          <= 8'h00;
            sdc_r          <= 1'b0;
            bit_r          <= 4'd0;
            shift_r        <= 8'h00;
            rdc_r          <= 1'b0;
            din_r          <= 1'b0;
            treset_r       <= 1'b0;
            tx_sent_r      <= 1'b0;
            tx_sent_ctrl_r <= 1'b0;
            rx_valid_r     <= 1'b0;
            rx_ctrl_r      <= 1'b0;
            rx_byte_r      <= 8'h00;
        end else begin
            txb_r          <= txb_next_s;
            sdc_r          <= sdc_next_s;
            bit_r          <= bit_next_s;
            shift_r        <= shift_next_s;
            rdc_r          <= rdc_next_s;
            din_r          <= din_next_s;
            treset_r       <= host_treset;
            tx_sent_r      <= sent_s;
            tx_sent_ctrl_r <= tx_sent_ctrl_next_s;
            rx_valid_r     <= ack_s;
            rx_ctrl_r      <= rx_ctrl_next_s;
            rx_byte_r      <= rx_byte_next_s;
        end
    end

    assign link.din     = din_r;
    assign link.treset  = treset_r;
    assign tx_sent      = tx_sent_r;
    assign tx_sent_ctrl = tx_sent_ctrl_r;
    assign rx_valid     = rx_valid_r;
    assign rx_ctrl      = rx_ctrl_r;
    assign rx_byte      = rx_byte_r;

`ifdef TIPI_LINK_STATS_EN
    logic [0:15] tx_retries_r, rx_retries_r;
    logic        tx_retry_s, rx_retry_s;

    // A reload out of SEND_DONE without a sent pulse is a master-requested resend.
    assign tx_retry_s = (state_r == ST_SEND_DONE) && load_tx_s && !sent_s;
    assign rx_retry_s = (state_r == ST_RECV_DONE) && start_rx_s;

    // Saturating retry counters for link diagnostics.
    always_ff @(posedge clk) begin
        if (reset || stats_clr) begin
            tx_retries_r <= 16'h0000;
            rx_retries_r <= 16'h0000;
        end else begin
            if (tx_retry_s && (tx_retries_r != 16'hFFFF)) begin
                tx_retries_r <= tx_retries_r + 16'd1;
            end
            if (rx_retry_s && (rx_retries_r != 16'hFFFF)) begin
                rx_retries_r <= rx_retries_r + 16'd1;
            end
        end
    end

    assign tx_retries = tx_retries_r;
    assign rx_retries = rx_retries_r;
`endif

endmodule

// File: doc/tipi_link_target.md
Name: tipi_link_target

Overview:
- Link-partner endpoint for the TIPI 3-wire serial link; sits on the far side of the wires driven by the TIPI MMIO master.
- Consumes the master's `tclk`/`rt`/`le`/`dout`/`dc` and produces `din`. Serialises TC/TD bytes to the master and deserialises RC/RD bytes from it.
- Used as the on-board loopback/bridge partner, and as the bench model for the master.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on every link input; minimum 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- link_tclk  in  1  link clock from master
- link_rt  in  1  1 = target transmits to master, 0 = master transmits
- link_le  in  1  byte start / acknowledge strobe
- link_dout  in  1  master serial data
- link_dc  in  1  1 = data byte, 0 = control byte
- link_din  out  1  target serial data / parity to master
- link_treset  out  1  reset request to master; registered copy of host_treset
- host_treset  in  1  reset request from host side
- tx_ctrl  in  [0:7]  control byte to send (TC)
- tx_data  in  [0:7]  data byte to send (TD)
- tx_sent  out  1  one-cycle pulse: master accepted a transmitted byte
- tx_sent_ctrl  out  1  qualifies tx_sent; 1 = it was the control byte
- rx_valid  out  1  one-cycle pulse: byte received and acknowledged
- rx_ctrl  out  1  qualifies rx_valid; 1 = control byte (RC), 0 = data (RD)
- rx_byte  out  [0:7]  received byte; held until next rx_valid

Behaviour:
- Reset values: link_din=0, link_treset=0, tx_sent=0, tx_sent_ctrl=0, rx_valid=0, rx_ctrl=0, rx_byte=0x00. State=IDLE, synchroniser flops cleared.
- Link electrical rule: master changes outputs at `tclk` falling edges. Target samples all inputs on the synchronised `tclk` rising edge ("rise") and updates `link_din` on the clk after the rise.
- Design target is clk ≥ 20× `tclk` toggle rate.
- Byte format: MSB (index 0) first, 8 bits, then one parity bit = XOR of the 8 bits (even parity).
- Decisions at each rise, using sampled rt/le/dc:
  - rt=1, le=1: latch byte B = dc ? tx_data : tx_ctrl; remember dc as sdc; din<=B[0]; state=SEND, bit=1.
  - SEND: rises 2..8 drive B[1..7]; the 9th rise drives parity; state=SEND_DONE.
  - SEND_DONE, next rise:
    - rt=1, le=1, dc==sdc: retry; reload the same selection (fresh tx_* value) and restart.
    - dc!=sdc or rt=0: pulse tx_sent with tx_sent_ctrl=~sdc, then process this rise as a new event.
  - rt=0, le=0, not in RECV: start RECV; shift dout as bit 0, bit=1.
  - RECV: shift dout on each rise. On the 8th bit, din<=XOR(all 8 bits incl. the one just sampled) on the following clk, and remember dc as rdc; state=RECV_DONE.
  - RECV_DONE, next rise:
    - le=1: ack; rx_byte<=shifted byte, rx_ctrl<=~rdc, rx_valid pulse; state=IDLE.
    - rt=0, le=0: master retry; restart RECV with this rise as bit 0.
  - rt change mid-byte: abort the current byte without any pulse, then evaluate the rise fresh.
- IDLE with no rise: din holds its last value; no pulses.
- Reset mid-byte: returns to IDLE immediately; the master recovers via its own retry.
- Simultaneous tx_sent and start of next byte on the same rise are allowed; both occur.

Optional Feature:
- Macro `TIPI_LINK_STATS_EN`.
- Defined:
  - Adds outputs tx_retries [0:15] and rx_retries [0:15], both saturating at 0xFFFF.
  - tx_retries increments on each SEND_DONE retry; rx_retries increments on each RECV_DONE retry.
  - Both cleared by reset and by input stats_clr (in, 1).
- Undefined: those ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
- tx_data=0xA5, tx_ctrl=0x3C, master reads two bytes → master gets TD=0xA5 (parity 0) then TC=0x3C (parity 0); tx_sent pulses twice, with tx_sent_ctrl 0 then 1.
- Master sends RD=0x81, then RC=0x7F → rx_valid with rx_ctrl=0, rx_byte=0x81, din=0 in the bit-7 phase; then rx_valid with rx_ctrl=1, rx_byte=0x7F, din=1.
- Force master-side parity mismatch on the first TD send → le=1 with dc unchanged; target resends 0xA5 with no tx_sent; second attempt accepted; tx_retries=1 when `TIPI_LINK_STATS_EN` is defined.
- Master restarts an RD send after the parity phase (le stays 0) → no rx_valid for the first attempt; single rx_valid for the second; rx_retries=1.
- Assert reset after 4 bits of an RD receive → all outputs at reset values next clk; the following full byte 0x55 is received correctly.
- host_treset 0→1 → link_treset=1 one clk later; no link activity is disturbed.
